// File: rtl/mdr_pkg.sv
// Shared MDR types: operation encoding, operand width, and the host-side
// sequencer state set.
package mdr_pkg;

  localparam int DW_MDR = 16;

  typedef enum logic [1:0] {
    OP_MULT = 2'd0,
    OP_DIV  = 2'd1,
    OP_SQRT = 2'd2
  } op_bus;

  typedef enum logic [2:0] {
    H_IDLE,
    H_SYNC,
    H_WAIT_X,
    H_LOAD_X,
    H_WAIT_Y,
    H_LOAD_Y,
    H_WAIT_DONE,
    H_RESP
  } host_state_e;

  localparam int HOST_TIMEOUT_DEFAULT = 1023;

  // States in which the sequencer depends on the MDR answering.
  function automatic logic is_wait_state(host_state_e s);
    return (s == H_SYNC) || (s == H_WAIT_X) || (s == H_WAIT_Y) || (s == H_WAIT_DONE);
  endfunction

endpackage

// File: rtl/mdr_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear and flags the
// TIMEOUT_CYC-th one, so a waiting state is left after exactly TIMEOUT_CYC cycles.
module mdr_watchdog
  import mdr_pkg::*;
#(
  parameter int TIMEOUT_CYC = HOST_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != CW'(TIMEOUT_CYC))) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mdr_host_sequencer.sv
// Initiator for the MDR start/load handshake: takes one command, drives the
// MDR through start, X load and optional Y load, and returns the outcome.
module mdr_host_sequencer
  import mdr_pkg::*;
#(
  parameter int DW          = DW_MDR,
  parameter int TIMEOUT_CYC = HOST_TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  op_bus         cmd_op,
  input  logic [DW-1:0] cmd_x,
  input  logic [DW-1:0] cmd_y,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_result,
  output logic [DW-1:0] rsp_remainder,
  output logic          rsp_error,
  output logic          rsp_timeout,
  output logic          mdr_start,
  output logic          mdr_load,
  output op_bus         mdr_op,
  output logic [DW-1:0] mdr_data_x,
  output logic [DW-1:0] mdr_data_y,
  input  logic          mdr_load_x,
  input  logic          mdr_load_y,
  input  logic          mdr_ready,
  input  logic          mdr_error,
  input  logic [DW-1:0] mdr_result,
  input  logic [DW-1:0] mdr_remainder
);

  host_state_e state, state_n;
  logic        err_flag, err_n;
  logic        start_n, accept, capture, abort;
  logic        wd_expired;

  mdr_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_n != state),
    .enable  (is_wait_state(state)),
    .expired (wd_expired)
  );

  always_comb begin
    state_n = state;
    err_n   = err_flag;
    start_n = 1'b0;
    accept  = 1'b0;
    capture = 1'b0;
    abort   = 1'b0;
    unique case (state)
      H_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept  = 1'b1;
          err_n   = 1'b0;
          state_n = H_SYNC;
        end
      end
      // Start is raised in the last H_SYNC cycle, so it is already low in H_WAIT_X.
      H_SYNC: begin
        if (mdr_start)       state_n = H_WAIT_X;
        else if (mdr_ready)  start_n = 1'b1;
        else if (wd_expired) abort   = 1'b1;
      end
      H_WAIT_X: begin
        if (mdr_load_x)      state_n = H_LOAD_X;
        else if (wd_expired) abort   = 1'b1;
      end
      H_LOAD_X: state_n = (mdr_op == OP_SQRT) ? H_WAIT_DONE : H_WAIT_Y;
      H_WAIT_Y: begin
        if (mdr_error) begin
          err_n   = 1'b1;
          state_n = H_WAIT_DONE;
        end else if (mdr_load_y && !mdr_load_x) begin
          state_n = H_LOAD_Y;
        end else if (wd_expired) begin
          abort = 1'b1;
        end
      end
      H_LOAD_Y: state_n = H_WAIT_DONE;
      H_WAIT_DONE: begin
        if (mdr_error) err_n = 1'b1;
        if (mdr_ready) begin
          capture = 1'b1;
          state_n = H_RESP;
        end else if (wd_expired) begin
          abort = 1'b1;
        end
      end
      H_RESP: begin
        if (rsp_valid && rsp_ready) begin
          err_n   = 1'b0;
          state_n = H_IDLE;
        end
      end
      default: state_n = H_IDLE;
    endcase
    if (abort) state_n = H_RESP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= H_IDLE;
      err_flag      <= 1'b0;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_result    <= '0;
      rsp_remainder <= '0;
      rsp_error     <= 1'b0;
      rsp_timeout   <= 1'b0;
      mdr_start     <= 1'b0;
      mdr_load      <= 1'b0;
      mdr_op        <= OP_MULT;
      mdr_data_x    <= '0;
      mdr_data_y    <= '0;
    end else begin
      state     <= state_n;
      err_flag  <= err_n;
      cmd_ready <= (state_n == H_IDLE);
      rsp_valid <= (state_n == H_RESP);
      mdr_start <= start_n;
      mdr_load  <= (state_n == H_LOAD_X) || (state_n == H_LOAD_Y);
      if (accept) begin
        mdr_op     <= cmd_op;
        mdr_data_x <= cmd_x;
        mdr_data_y <= cmd_y;
      end
      if (capture) begin
        rsp_result    <= mdr_result;
        rsp_remainder <= mdr_remainder;
        rsp_error     <= err_n;
        rsp_timeout   <= 1'b0;
      end else if (abort) begin
        rsp_result    <= '0;
        rsp_remainder <= '0;
        rsp_error     <= 1'b1;
        rsp_timeout   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mdr_host_sequencer.sv
// Directed bench for mdr_host_sequencer against a small behavioural MDR model.
module tb_mdr_host_sequencer;
  import mdr_pkg::*;

  localparam int DW = DW_MDR;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  op_bus         cmd_op = OP_MULT;
  logic [DW-1:0] cmd_x = '0;
  logic [DW-1:0] cmd_y = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_result, rsp_remainder;
  logic          rsp_error, rsp_timeout;
  logic          mdr_start, mdr_load;
  op_bus         mdr_op;
  logic [DW-1:0] mdr_data_x, mdr_data_y;
  logic          m_load_x, m_load_y, m_ready, m_error;
  logic [DW-1:0] m_res, m_rem;

  int errors = 0;
  int checks = 0;
  int n_start = 0, n_load = 0, n_viol = 0;
  logic stall_y = 1'b0;

  mdr_host_sequencer #(.DW(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_remainder(rsp_remainder), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .mdr_start(mdr_start), .mdr_load(mdr_load), .mdr_op(mdr_op),
    .mdr_data_x(mdr_data_x), .mdr_data_y(mdr_data_y),
    .mdr_load_x(m_load_x), .mdr_load_y(m_load_y), .mdr_ready(m_ready), .mdr_error(m_error),
    .mdr_result(m_res), .mdr_remainder(m_rem)
  );

  always #5 clk = ~clk;

  // Behavioural MDR: start -> load X -> (load Y) -> 3 processing cycles -> ready.
  typedef enum logic [2:0] {M_IDLE, M_LX, M_LY, M_PROC, M_ERR} mstate_e;
  mstate_e       mst;
  op_bus         op_l;
  logic [DW-1:0] x_l, y_l;
  int            mcnt, sq_r;

  function automatic int isqrt(int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  always_comb sq_r = isqrt(int'(x_l));

  assign m_ready  = (mst == M_IDLE);
  assign m_load_x = (mst == M_LX);
  assign m_load_y = (mst == M_LY) && !stall_y;
  assign m_error  = (mst == M_ERR);

  always @(posedge clk) begin
    if (rst) begin
      mst <= M_IDLE; op_l <= OP_MULT; x_l <= '0; y_l <= '0;
      m_res <= '0; m_rem <= '0; mcnt <= 0;
    end else begin
      case (mst)
        M_IDLE: if (mdr_start) begin mst <= M_LX; op_l <= mdr_op; end
        M_LX: if (mdr_load) begin
          x_l  <= mdr_data_x;
          mcnt <= 0;
          if (op_l == OP_SQRT) mst <= M_PROC;
          else if (op_l == OP_DIV && mdr_data_x == '0) mst <= M_ERR;
          else mst <= M_LY;
        end
        M_LY: if (mdr_load && !stall_y) begin
          y_l  <= mdr_data_y;
          mcnt <= 0;
          mst  <= (op_l == OP_DIV && mdr_data_y == '0) ? M_ERR : M_PROC;
        end
        M_PROC: begin
          mcnt <= mcnt + 1;
          if (mcnt == 2) begin
            mst <= M_IDLE;
            case (op_l)
              OP_MULT: begin m_res <= x_l * y_l; m_rem <= '0; end
              OP_DIV:  begin m_res <= x_l / y_l; m_rem <= x_l % y_l; end
              default: begin m_res <= DW'(sq_r); m_rem <= DW'(int'(x_l) - sq_r * sq_r); end
            endcase
          end
        end
        M_ERR: begin
          mcnt <= mcnt + 1;
          if (mcnt == 1) begin mst <= M_IDLE; m_res <= '0; m_rem <= '0; end
        end
        default: mst <= M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (mdr_start) n_start++;
    if (mdr_load) n_load++;
    if (mdr_start && mdr_load) n_viol++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    op_bus         op;
    logic [DW-1:0] x, y, res, rem;
    logic          err;
    int            loads;
    logic          alter;
  } vec_t;

  vec_t vecs[9];

  task automatic wait_cmd_ready(input string tag);
    int t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    check({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_cmd(input vec_t v, input string tag);
    int t, s0, l0;
    wait_cmd_ready(tag);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_x = v.x; cmd_y = v.y;
    s0 = n_start; l0 = n_load;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (v.alter) begin cmd_x = ~v.x; cmd_y = v.y + 16'd7; cmd_op = OP_SQRT; end
    t = 0;
    while (!rsp_valid && t < 200) begin @(negedge clk); t++; end
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".mdr_op"}, 32'(mdr_op), 32'(v.op));
    check({tag, ".mdr_data_x"}, 32'(mdr_data_x), 32'(v.x));
    if (v.op != OP_SQRT) check({tag, ".mdr_data_y"}, 32'(mdr_data_y), 32'(v.y));
    check({tag, ".result"}, 32'(rsp_result), 32'(v.res));
    check({tag, ".remainder"}, 32'(rsp_remainder), 32'(v.rem));
    check({tag, ".error"}, 32'(rsp_error), 32'(v.err));
    check({tag, ".timeout"}, 32'(rsp_timeout), 32'd0);
    check({tag, ".start_pulses"}, 32'(n_start - s0), 32'd1);
    check({tag, ".load_pulses"}, 32'(n_load - l0), 32'(v.loads));
    check({tag, ".cmd_ready_busy"}, 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, ".rsp_dropped"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int t, k, seen;
    logic stable;
    vecs[0] = '{OP_MULT, 16'd7,   16'hFFFD, 16'hFFEB, 16'd0, 1'b0, 2, 1'b0};
    vecs[1] = '{OP_DIV,  16'd17,  16'd5,    16'd3,    16'd2, 1'b0, 2, 1'b1};
    vecs[2] = '{OP_SQRT, 16'd26,  16'd99,   16'd5,    16'd1, 1'b0, 1, 1'b0};
    vecs[3] = '{OP_DIV,  16'd17,  16'd0,    16'd0,    16'd0, 1'b1, 2, 1'b0};
    vecs[4] = '{OP_MULT, 16'd2,   16'd3,    16'd6,    16'd0, 1'b0, 2, 1'b0};
    vecs[5] = '{OP_DIV,  16'd0,   16'd5,    16'd0,    16'd0, 1'b1, 1, 1'b0};
    vecs[6] = '{OP_MULT, 16'd2,   16'd3,    16'd6,    16'd0, 1'b0, 2, 1'b0};
    vecs[7] = '{OP_MULT, 16'd300, 16'd300,  16'h5F90, 16'd0, 1'b0, 2, 1'b0};
    vecs[8] = '{OP_SQRT, 16'd144, 16'd0,    16'd12,   16'd0, 1'b0, 1, 1'b1};

    repeat (3) @(negedge clk);
    check("reset.cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset.outputs", 32'({rsp_valid, rsp_error, rsp_timeout, mdr_start, mdr_load, mdr_op}), 32'd0);
    check("reset.data", 32'({mdr_data_x, rsp_result}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

    // Watchdog: MDR never requests Y.
    stall_y = 1'b1;
    wait_cmd_ready("tmo");
    cmd_valid = 1'b1; cmd_op = OP_DIV; cmd_x = 16'd9; cmd_y = 16'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (!mdr_load && t < 50) begin @(negedge clk); t++; end
    check("tmo.load_x_seen", 32'(mdr_load), 32'd1);
    k = 0;
    do begin @(negedge clk); k++; end while (!rsp_valid && k < 40);
    check("tmo.latency", 32'(k), 32'(TO + 1));
    check("tmo.rsp_timeout", 32'(rsp_timeout), 32'd1);
    check("tmo.rsp_error", 32'(rsp_error), 32'd1);
    check("tmo.result", 32'({rsp_result, rsp_remainder}), 32'd0);
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!rsp_valid || cmd_ready || !rsp_timeout || !rsp_error || rsp_result != '0) stable = 1'b0;
    end
    check("tmo.hold_stable", 32'(stable), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    stall_y = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset while the MDR is processing.
    wait_cmd_ready("rstmid");
    cmd_valid = 1'b1; cmd_op = OP_MULT; cmd_x = 16'd4; cmd_y = 16'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    seen = 0; t = 0;
    while (seen < 2 && t < 60) begin @(negedge clk); t++; if (mdr_load) seen++; end
    check("rstmid.loads", 32'(seen), 32'd2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid.ctrl", 32'({cmd_ready, rsp_valid, rsp_error, rsp_timeout, mdr_start, mdr_load, mdr_op}), 32'd0);
    check("rstmid.data", 32'({mdr_data_x, mdr_data_y}), 32'd0);
    check("rstmid.rsp", 32'({rsp_result, rsp_remainder}), 32'd0);
    rst = 1'b0;
    run_cmd('{OP_MULT, 16'd6, 16'd7, 16'd42, 16'd0, 1'b0, 2, 1'b0}, "after_rst");

    check("start_load_overlap", 32'(n_viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
